// File: rtl/vx_avs_multibank_adapter_pkg.sv
// Shared constants and helpers for the multibank Avalon adapter.
// The optional AVS_PERF_EN build adds performance counters to the top level.
package vx_avs_multibank_adapter_pkg;

  localparam int AVS_BURSTW = 8;

  // Width of a counter able to hold the values 0..n inclusive.
  function automatic int pending_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Low address bits pick the bank; a single bank always maps to index 0.
  function automatic int bank_of(input logic [63:0] addr, input int bank_bits);
    logic [63:0] mask;
    if (bank_bits == 0) return 0;
    mask = (64'd1 << bank_bits) - 64'd1;
    return int'(addr & mask);
  endfunction

endpackage

// File: rtl/vx_avs_bank_channel.sv
// Per-bank read bookkeeping: outstanding-read credits, tag queue and read-data queue.
// With AVS_PERF_EN the live pending count is exported for the peak tracker.
module vx_avs_bank_channel
  import vx_avs_multibank_adapter_pkg::*;
#(
  parameter int DATAW = 512,
  parameter int TAGW  = 8,
  parameter int QSIZE = 16,
  parameter int PW    = pending_width(QSIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_fire,
  input  logic [TAGW-1:0]  req_tag,
  input  logic             rdv,
  input  logic [DATAW-1:0] rdata,
  input  logic             pop,
  output logic             head_valid,
  output logic [DATAW-1:0] head_data,
  output logic [TAGW-1:0]  head_tag,
  output logic             rd_ok
`ifdef AVS_PERF_EN
  ,
  output logic [PW-1:0]    pending
`endif
);

  logic [PW-1:0] pend_q;
  logic [PW-1:0] pend_next;
  logic          tag_valid;
  logic          data_valid;

  always_comb begin
    pend_next = pend_q;
    if (req_fire && !pop)      pend_next = pend_q + PW'(1);
    else if (!req_fire && pop) pend_next = pend_q - PW'(1);
  end

  // Credits cover the whole lifetime of a read, so neither queue can overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      rd_ok  <= 1'b1;
    end else begin
      pend_q <= pend_next;
      rd_ok  <= (pend_next != PW'(QSIZE));
    end
  end

`ifdef AVS_PERF_EN
  assign pending = pend_q;
`endif

  vx_avs_fifo #(.WIDTH(TAGW), .DEPTH(QSIZE)) u_tagq (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .din   (req_tag),
    .pop   (pop),
    .valid (tag_valid),
    .dout  (head_tag)
  );

  vx_avs_fifo #(.WIDTH(DATAW), .DEPTH(QSIZE)) u_dataq (
    .clk   (clk),
    .rst   (rst),
    .push  (rdv),
    .din   (rdata),
    .pop   (pop),
    .valid (data_valid),
    .dout  (head_data)
  );

  assign head_valid = data_valid && tag_valid;

endmodule

// File: rtl/vx_avs_fifo.sv
// Small synchronous FIFO with a combinational head read.
module vx_avs_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign valid = (count != '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vx_avs_multibank_adapter.sv
// Splits one DRAM request stream across NUM_BANKS Avalon-MM ports and merges read responses.
// Define AVS_PERF_EN to add the perf_* counter outputs.
module vx_avs_multibank_adapter
  import vx_avs_multibank_adapter_pkg::*;
#(
  parameter int AVS_DATAW     = 512,
  parameter int AVS_ADDRW     = 26,
  parameter int NUM_BANKS     = 2,
  parameter int REQ_TAGW      = 8,
  parameter int RD_QUEUE_SIZE = 16,
  parameter int AVS_BYTEENW   = AVS_DATAW / 8,
  parameter int BANK_BITS     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
  parameter int REQ_ADDRW     = AVS_ADDRW + BANK_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            dram_req_valid,
  input  logic                            dram_req_rw,
  input  logic [AVS_BYTEENW-1:0]          dram_req_byteen,
  input  logic [REQ_ADDRW-1:0]            dram_req_addr,
  input  logic [AVS_DATAW-1:0]            dram_req_data,
  input  logic [REQ_TAGW-1:0]             dram_req_tag,
  output logic                            dram_req_ready,
  output logic                            dram_rsp_valid,
  output logic [AVS_DATAW-1:0]            dram_rsp_data,
  output logic [REQ_TAGW-1:0]             dram_rsp_tag,
  input  logic                            dram_rsp_ready,
  output logic [NUM_BANKS-1:0]            avs_read,
  output logic [NUM_BANKS-1:0]            avs_write,
  output logic [NUM_BANKS*AVS_ADDRW-1:0]  avs_address,
  output logic [NUM_BANKS*AVS_BYTEENW-1:0] avs_byteenable,
  output logic [NUM_BANKS*AVS_DATAW-1:0]  avs_writedata,
  output logic [NUM_BANKS*AVS_BURSTW-1:0] avs_burstcount,
  input  logic [NUM_BANKS-1:0]            avs_waitrequest,
  input  logic [NUM_BANKS*AVS_DATAW-1:0]  avs_readdata,
  input  logic [NUM_BANKS-1:0]            avs_readdatavalid
`ifdef AVS_PERF_EN
  ,
  output logic [63:0]                     perf_rd_reqs,
  output logic [63:0]                     perf_wr_reqs,
  output logic [63:0]                     perf_stalls,
  output logic [pending_width(RD_QUEUE_SIZE)-1:0] perf_pending_max
`endif
);

  localparam int PW    = pending_width(RD_QUEUE_SIZE);
  localparam int BIDXW = (BANK_BITS > 0) ? BANK_BITS : 1;

  // Handshake: a request transfers on a cycle where dram_req_valid && dram_req_ready,
  // and a response transfers where dram_rsp_valid && dram_rsp_ready; a presented
  // response keeps its data and tag unchanged until it transfers.

  logic [BIDXW-1:0]     req_bank;
  logic [NUM_BANKS-1:0] rd_ok;
  logic [NUM_BANKS-1:0] rd_fire;
  logic [NUM_BANKS-1:0] head_valid;
  logic [NUM_BANKS-1:0] pop;
  logic [AVS_DATAW-1:0] head_data [NUM_BANKS];
  logic [REQ_TAGW-1:0]  head_tag  [NUM_BANKS];
  logic [BIDXW-1:0]     rr_ptr;
  logic [BIDXW-1:0]     grant_rr;
  logic [BIDXW-1:0]     grant_q;
  logic [BIDXW-1:0]     grant;
  logic                 lock_q;
  logic                 rr_found;
  logic                 rsp_fire;

  assign req_bank = BIDXW'(bank_of(64'(dram_req_addr), BANK_BITS));

  always_comb begin
    avs_read       = '0;
    avs_write      = '0;
    rd_fire        = '0;
    dram_req_ready = !avs_waitrequest[req_bank] && (dram_req_rw || rd_ok[req_bank]);
    avs_read[req_bank]  = dram_req_valid && !dram_req_rw && rd_ok[req_bank];
    avs_write[req_bank] = dram_req_valid && dram_req_rw;
    rd_fire[req_bank]   = dram_req_valid && dram_req_ready && !dram_req_rw;
  end

  assign avs_address    = {NUM_BANKS{dram_req_addr[REQ_ADDRW-1:BANK_BITS]}};
  assign avs_byteenable = {NUM_BANKS{dram_req_byteen}};
  assign avs_writedata  = {NUM_BANKS{dram_req_data}};
  assign avs_burstcount = {NUM_BANKS{AVS_BURSTW'(1)}};

`ifdef AVS_PERF_EN
  logic [PW-1:0] pending [NUM_BANKS];
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    vx_avs_bank_channel #(
      .DATAW (AVS_DATAW),
      .TAGW  (REQ_TAGW),
      .QSIZE (RD_QUEUE_SIZE),
      .PW    (PW)
    ) u_chan (
      .clk        (clk),
      .rst        (reset),
      .req_fire   (rd_fire[b]),
      .req_tag    (dram_req_tag),
      .rdv        (avs_readdatavalid[b]),
      .rdata      (avs_readdata[b*AVS_DATAW +: AVS_DATAW]),
      .pop        (pop[b]),
      .head_valid (head_valid[b]),
      .head_data  (head_data[b]),
      .head_tag   (head_tag[b]),
      .rd_ok      (rd_ok[b])
`ifdef AVS_PERF_EN
      ,
      .pending    (pending[b])
`endif
    );
  end

  // Round-robin search starting at rr_ptr; a stalled grant is frozen in grant_q.
  always_comb begin
    grant_rr = rr_ptr;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!rr_found && head_valid[(int'(rr_ptr) + i) % NUM_BANKS]) begin
        rr_found = 1'b1;
        grant_rr = BIDXW'((int'(rr_ptr) + i) % NUM_BANKS);
      end
    end
    grant          = lock_q ? grant_q : grant_rr;
    dram_rsp_valid = |head_valid;
    dram_rsp_data  = head_data[grant];
    dram_rsp_tag   = head_tag[grant];
    rsp_fire       = dram_rsp_valid && dram_rsp_ready;
    pop            = '0;
    pop[grant]     = rsp_fire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
    end else if (rsp_fire) begin
      rr_ptr <= (grant == BIDXW'(NUM_BANKS - 1)) ? '0 : grant + BIDXW'(1);
      lock_q <= 1'b0;
    end else if (dram_rsp_valid) begin
      lock_q  <= 1'b1;
      grant_q <= grant;
    end
  end

`ifdef AVS_PERF_EN
  logic [PW-1:0] pend_now_max;

  always_comb begin
    pend_now_max = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (pending[b] > pend_now_max) pend_now_max = pending[b];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rd_reqs     <= '0;
      perf_wr_reqs     <= '0;
      perf_stalls      <= '0;
      perf_pending_max <= '0;
    end else begin
      if (dram_req_valid && dram_req_ready && !dram_req_rw) perf_rd_reqs <= perf_rd_reqs + 64'd1;
      if (dram_req_valid && dram_req_ready && dram_req_rw)  perf_wr_reqs <= perf_wr_reqs + 64'd1;
      if (dram_req_valid && !dram_req_ready)                perf_stalls  <= perf_stalls + 64'd1;
      if (pend_now_max > perf_pending_max) perf_pending_max <= pend_now_max;
    end
  end
`endif

endmodule

// File: tb/tb_vx_avs_multibank_adapter.sv
// Directed bench for vx_avs_multibank_adapter: two banks, 4-deep read queues.
module tb_vx_avs_multibank_adapter;

  localparam int DW  = 64;
  localparam int AW  = 26;
  localparam int NB  = 2;
  localparam int TW  = 8;
  localparam int QS  = 4;
  localparam int BEW = DW / 8;
  localparam int RAW = AW + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            dram_req_valid = 1'b0;
  logic            dram_req_rw = 1'b0;
  logic [BEW-1:0]  dram_req_byteen = '0;
  logic [RAW-1:0]  dram_req_addr = '0;
  logic [DW-1:0]   dram_req_data = '0;
  logic [TW-1:0]   dram_req_tag = '0;
  logic            dram_req_ready;
  logic            dram_rsp_valid;
  logic [DW-1:0]   dram_rsp_data;
  logic [TW-1:0]   dram_rsp_tag;
  logic            dram_rsp_ready = 1'b0;
  logic [NB-1:0]   avs_read;
  logic [NB-1:0]   avs_write;
  logic [NB*AW-1:0]  avs_address;
  logic [NB*BEW-1:0] avs_byteenable;
  logic [NB*DW-1:0]  avs_writedata;
  logic [NB*8-1:0]   avs_burstcount;
  logic [NB-1:0]     avs_waitrequest = '0;
  logic [NB*DW-1:0]  avs_readdata = '0;
  logic [NB-1:0]     avs_readdatavalid = '0;
`ifdef AVS_PERF_EN
  logic [63:0] perf_rd_reqs;
  logic [63:0] perf_wr_reqs;
  logic [63:0] perf_stalls;
  logic [2:0]  perf_pending_max;
`endif

  int checks = 0;
  int errors = 0;
  logic [TW+DW-1:0] exp_q[$];

  vx_avs_multibank_adapter #(
    .AVS_DATAW     (DW),
    .AVS_ADDRW     (AW),
    .NUM_BANKS     (NB),
    .REQ_TAGW      (TW),
    .RD_QUEUE_SIZE (QS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .dram_req_valid    (dram_req_valid),
    .dram_req_rw       (dram_req_rw),
    .dram_req_byteen   (dram_req_byteen),
    .dram_req_addr     (dram_req_addr),
    .dram_req_data     (dram_req_data),
    .dram_req_tag      (dram_req_tag),
    .dram_req_ready    (dram_req_ready),
    .dram_rsp_valid    (dram_rsp_valid),
    .dram_rsp_data     (dram_rsp_data),
    .dram_rsp_tag      (dram_rsp_tag),
    .dram_rsp_ready    (dram_rsp_ready),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_address       (avs_address),
    .avs_byteenable    (avs_byteenable),
    .avs_writedata     (avs_writedata),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid)
`ifdef AVS_PERF_EN
    ,
    .perf_rd_reqs      (perf_rd_reqs),
    .perf_wr_reqs      (perf_wr_reqs),
    .perf_stalls       (perf_stalls),
    .perf_pending_max  (perf_pending_max)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    dram_req_valid    = 1'b0;
    dram_req_rw       = 1'b0;
    dram_req_addr     = '0;
    dram_req_tag      = '0;
    avs_waitrequest   = '0;
    avs_readdatavalid = '0;
    dram_rsp_ready    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Driver: present one read for a cycle and check the handshake it gets.
  task automatic do_read(input logic [RAW-1:0] addr, input logic [TW-1:0] tag,
                         input logic exp_ready);
    logic [NB-1:0] exp_rd;
    exp_rd = exp_ready ? (NB'(1) << addr[0]) : '0;
    dram_req_valid = 1'b1;
    dram_req_rw    = 1'b0;
    dram_req_addr  = addr;
    dram_req_tag   = tag;
    @(negedge clk);
    chk("req_ready_rd", dram_req_ready, exp_ready);
    chk("avs_read", avs_read, exp_rd);
    @(posedge clk); #1;
    dram_req_valid = 1'b0;
  endtask

  // Driver: one cycle of Avalon read data on a bank; optionally record the expected response.
  task automatic give(input int bank, input logic [DW-1:0] data, input logic [TW-1:0] tag,
                      input logic record);
    avs_readdatavalid[bank]     = 1'b1;
    avs_readdata[bank*DW +: DW] = data;
    if (record) exp_q.push_back({tag, data});
    @(posedge clk); #1;
    avs_readdatavalid = '0;
  endtask

  // Scoreboard: accept responses with ready high and compare against the expected queue.
  task automatic drain(input int n, input int budget);
    int got;
    logic [TW+DW-1:0] e;
    got = 0;
    dram_rsp_ready = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (dram_rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", dram_rsp_tag, '1);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_tag", dram_rsp_tag, e[TW+DW-1:DW]);
          chk("rsp_data", dram_rsp_data, e[DW-1:0]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    dram_rsp_ready = 1'b0;
    chk("rsp_count", got, n);
  endtask

  initial begin
    idle_inputs();

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", dram_rsp_valid, 1'b0);
    chk("rst_burstcount", avs_burstcount, 16'h0101);
    chk("rst_avs_read", avs_read, 2'b00);
    chk("rst_avs_write", avs_write, 2'b00);
    chk("rst_req_ready", dram_req_ready, 1'b1);
    @(posedge clk); #1 reset = 1'b0;

    // Two banks answer out of order; bank 1 first.
    do_read(27'h4, 8'h11, 1'b1);
    do_read(27'h5, 8'h22, 1'b1);
    avs_readdatavalid[1]      = 1'b1;
    avs_readdata[DW +: DW]    = 64'hB;
    exp_q.push_back({8'h22, 64'hB});
    @(negedge clk);
    chk("lat_not_yet", dram_rsp_valid, 1'b0);
    @(posedge clk); #1;
    avs_readdatavalid = '0;
    @(negedge clk);
    chk("lat_valid", dram_rsp_valid, 1'b1);
    chk("lat_tag", dram_rsp_tag, 8'h22);
    @(posedge clk); #1;
    give(0, 64'hA, 8'h11, 1'b1);
    drain(2, 4);
    @(negedge clk);
    chk("t1_idle", dram_rsp_valid, 1'b0);
    @(posedge clk); #1;

    // Credit limit: fifth read to bank 0 stalls, bank 1 still proceeds.
    apply_reset();
    for (int i = 0; i < QS; i++) do_read(RAW'(2 * i), TW'(i + 1), 1'b1);
    do_read(27'h8, 8'h05, 1'b0);
    do_read(27'h1, 8'h55, 1'b1);
    for (int i = 0; i < QS; i++) give(0, DW'(64'h100 + i), TW'(i + 1), 1'b1);
    drain(QS, QS + 2);
    give(1, 64'h555, 8'h55, 1'b1);
    drain(1, 3);
    do_read(27'h8, 8'h05, 1'b1);

    // Both banks hold three responses; round robin alternates.
    apply_reset();
    for (int i = 0; i < 3; i++) do_read(RAW'(2 * i), TW'(8'h60 + i), 1'b1);
    for (int i = 0; i < 3; i++) do_read(RAW'(2 * i + 1), TW'(8'h70 + i), 1'b1);
    for (int i = 0; i < 3; i++) begin
      avs_readdatavalid      = 2'b11;
      avs_readdata[0 +: DW]  = DW'(64'h600 + i);
      avs_readdata[DW +: DW] = DW'(64'h700 + i);
      exp_q.push_back({TW'(8'h60 + i), DW'(64'h600 + i)});
      exp_q.push_back({TW'(8'h70 + i), DW'(64'h700 + i)});
      @(posedge clk); #1;
    end
    avs_readdatavalid = '0;
    drain(6, 6);

    // Stalled grant on bank 0 holds while bank 1 sits at the round-robin pointer.
    apply_reset();
    do_read(27'h8, 8'h30, 1'b1);
    do_read(27'hA, 8'h31, 1'b1);
    do_read(27'h9, 8'h42, 1'b1);
    give(0, 64'h300, 8'h30, 1'b1);
    drain(1, 3);
    give(0, 64'h310, 8'h31, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        avs_readdatavalid[1]   = 1'b1;
        avs_readdata[DW +: DW] = 64'h420;
        exp_q.push_back({8'h42, 64'h420});
      end else begin
        avs_readdatavalid = '0;
      end
      @(negedge clk);
      chk("hold_valid", dram_rsp_valid, 1'b1);
      chk("hold_tag", dram_rsp_tag, 8'h31);
      chk("hold_data", dram_rsp_data, 64'h310);
      @(posedge clk); #1;
    end
    avs_readdatavalid = '0;
    drain(2, 4);

    // Write under waitrequest; writes never consume credit nor respond.
    apply_reset();
    dram_req_valid  = 1'b1;
    dram_req_rw     = 1'b1;
    dram_req_addr   = 27'h3;
    dram_req_data   = 64'hDEAD_BEEF;
    dram_req_byteen = 8'h0F;
    avs_waitrequest = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_wait_ready", dram_req_ready, 1'b0);
      chk("wr_wait_write", avs_write, 2'b10);
      @(posedge clk); #1;
    end
    avs_waitrequest = '0;
    @(negedge clk);
    chk("wr_ready", dram_req_ready, 1'b1);
    chk("wr_address", avs_address, {26'h1, 26'h1});
    chk("wr_data", avs_writedata[DW +: DW], 64'hDEAD_BEEF);
    chk("wr_byteen", avs_byteenable, 16'h0F0F);
    @(posedge clk); #1;
    dram_req_addr = 27'h0;
    for (int i = 0; i < QS + 1; i++) begin
      @(negedge clk);
      chk("wr_no_credit", dram_req_ready, 1'b1);
      @(posedge clk); #1;
    end
    dram_req_valid = 1'b0;
    dram_req_rw    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_no_rsp", dram_rsp_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Asynchronous reset with three reads in flight and one response waiting.
    apply_reset();
    for (int i = 0; i < 3; i++) do_read(RAW'(2 * i), TW'(8'h80 + i), 1'b1);
    give(0, 64'h800, 8'h80, 1'b0);
    @(negedge clk);
    chk("mid_valid", dram_rsp_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rsp_valid", dram_rsp_valid, 1'b0);
    chk("async_req_ready", dram_req_ready, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < QS; i++) do_read(RAW'(2 * i), TW'(8'h90 + i), 1'b1);
    do_read(27'h8, 8'h99, 1'b0);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
